// File: rtl/timer_pkg.sv
// Shared state encoding and BCD constants for the cook timer.
package timer_pkg;

  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned NUM_DIGITS     = 4;
  localparam int unsigned DIGITS_W       = DIGIT_W * NUM_DIGITS;
  localparam int unsigned STATE_W        = 3;
  localparam int unsigned DIGIT_MAX_ONES = 9;
  localparam int unsigned DIGIT_MAX_TENS = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } timer_state_e;

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD down-counting digit with parallel load; wraps 0 -> MAX on decrement.
module bcd_digit_dn
  import timer_pkg::*;
#(
  parameter int unsigned MAX = DIGIT_MAX_ONES
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow
);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (dec) begin
      q_d = (q_q == DIGIT_W'(0)) ? DIGIT_W'(MAX) : q_q - DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign borrow = dec & (q_q == DIGIT_W'(0));

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave countdown sequencer: keypad entry, start/stop/door interlock,
// per-second BCD countdown, magnetron enable and done indication.
module cook_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DONE_TICKS = 3
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                sec_tick,
  input  logic                key_valid,
  input  logic [DIGIT_W-1:0]  key_digit,
  input  logic                start,
  input  logic                stop,
  input  logic                door_closed,
  output logic [DIGITS_W-1:0] digits,
  output logic                magnetron,
  output logic                done,
  output logic [STATE_W-1:0]  state
);

  localparam int unsigned CNT_W = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

  timer_state_e        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                magnetron_q, done_q;
  logic [DIGITS_W-1:0] digits_q;
  logic                load_c, shift_c, dec_c;
  logic [DIGITS_W-1:0] load_val_c;
  logic                key_ok_c;
  logic                start_ok_c;
  logic [NUM_DIGITS-1:0] borrow_c;

  assign key_ok_c   = key_valid & (key_digit <= DIGIT_W'(DIGIT_MAX_ONES));
  assign start_ok_c = start & door_closed & (digits_q != '0)
                    & (digits_q[7:4] <= DIGIT_W'(DIGIT_MAX_TENS));
  assign load_val_c = shift_c ? {digits_q[DIGITS_W-DIGIT_W-1:0], key_digit} : '0;

  // Next-state, digit load/decrement strobes and DONE hold counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
    dec_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_ok_c) begin
          load_c  = 1'b1;
          shift_c = 1'b1;
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (stop) begin
          load_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (start_ok_c) begin
          state_d = ST_RUN;
        end else if (key_ok_c) begin
          load_c  = 1'b1;
          shift_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (!door_closed || stop) begin
          state_d = ST_PAUSE;
        end else if (sec_tick) begin
          dec_c = 1'b1;
          if (digits_q == DIGITS_W'(16'h0001)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          load_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (start && door_closed) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop || key_ok_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (sec_tick) begin
          if (cnt_q == CNT_W'(DONE_TICKS - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        load_c  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      magnetron_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      magnetron_q <= (state_d == ST_RUN);
      done_q      <= (state_d == ST_DONE);
    end
  end

  // Borrow ripples combinationally so 10:00 -> 09:59 lands in one cycle.
  bcd_digit_dn #(.MAX(DIGIT_MAX_ONES)) u_sec_ones (
    .clk(clk), .clr(clr), .load(load_c), .load_val(load_val_c[3:0]),
    .dec(dec_c), .q(digits_q[3:0]), .borrow(borrow_c[0])
  );
  bcd_digit_dn #(.MAX(DIGIT_MAX_TENS)) u_sec_tens (
    .clk(clk), .clr(clr), .load(load_c), .load_val(load_val_c[7:4]),
    .dec(borrow_c[0]), .q(digits_q[7:4]), .borrow(borrow_c[1])
  );
  bcd_digit_dn #(.MAX(DIGIT_MAX_ONES)) u_min_ones (
    .clk(clk), .clr(clr), .load(load_c), .load_val(load_val_c[11:8]),
    .dec(borrow_c[1]), .q(digits_q[11:8]), .borrow(borrow_c[2])
  );
  bcd_digit_dn #(.MAX(DIGIT_MAX_ONES)) u_min_tens (
    .clk(clk), .clr(clr), .load(load_c), .load_val(load_val_c[15:12]),
    .dec(borrow_c[2]), .q(digits_q[15:12]), .borrow(borrow_c[3])
  );

  assign digits    = digits_q;
  assign magnetron = magnetron_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule
